serial_link_chan_striper: RTL and testbench

Transmit-side channel striper for the multi-channel serial link. It accepts one wide payload per handshake and splits it into `NumChannels` equal slices. The slices are distributed over the physical channels that are currently enabled. When some channels are disabled, which is the degraded mode after a lane or channel failure, the payload is time-multiplexed over several beats on the remaining channels. The block sits between the link-layer packetizer and the per-channel physical layers, and it generalises the fixed single/multi-channel selection into runtime channel masking.

---
 rtl/serial_link_chan_striper.sv | 133 +++++++++++++
 tb/tb_serial_link_chan_striper.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_link_chan_striper.sv
// Transmit-side channel striper: splits one wide payload over the enabled channels,
// time-multiplexing it over several beats when only some channels are enabled.
module serial_link_chan_striper #(
    parameter int NumChannels = 4,
    parameter int ChanWidth   = 32
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic [NumChannels-1:0]                  cfg_chan_en_i,
    input  logic [NumChannels*ChanWidth-1:0]        data_i,
    input  logic                                    valid_i,
    output logic                                    ready_o,
    output logic [NumChannels-1:0][ChanWidth-1:0]   chan_data_o,
    output logic [NumChannels-1:0]                  chan_valid_o,
    input  logic [NumChannels-1:0]                  chan_ready_i,
    output logic                                    busy_o,
    output logic                                    cfg_err_o
);

    localparam int BW = (NumChannels > 1) ? $clog2(NumChannels) : 1;
    localparam int NW = $clog2(NumChannels + 1);
    localparam int SW = $clog2(NumChannels) + 1;
    localparam logic [SW-1:0] NCH_S = SW'(NumChannels);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                         r_state;
    state_t                         w_state_nxt;
    logic [NumChannels*ChanWidth-1:0] r_data;
    logic [NumChannels-1:0]         r_mask;
    logic [NW-1:0]                  r_nact;
    logic [BW-1:0]                  r_nbeat;
    logic [BW-1:0]                  r_beat;
    logic [NumChannels-1:0]         r_done;

    logic [SW-1:0]                  w_s [NumChannels];
    logic [NumChannels-1:0]         w_chan_valid;
    logic [NumChannels-1:0][ChanWidth-1:0] w_chan_data;
    logic                           w_beat_done;
    logic                           w_final;
    logic                           w_ready;
    logic                           w_accept;

    function automatic logic [NW-1:0] f_popcount(input logic [NumChannels-1:0] m);
        logic [NW-1:0] n;
        n = '0;
        for (int i = 0; i < NumChannels; i++) n = n + NW'(m[i]);
        return n;
    endfunction

    // Last beat index = ceil(NumChannels / nact) - 1, unrolled over constant divisors.
    function automatic logic [BW-1:0] f_nbeat(input logic [NW-1:0] n);
        logic [BW-1:0] b;
        b = '0;
        for (int k = 1; k <= NumChannels; k++) begin
            if (n == NW'(k)) b = BW'((NumChannels + k - 1) / k - 1);
        end
        return b;
    endfunction

    function automatic logic [SW-1:0] f_rank(input logic [NumChannels-1:0] m, input int c);
        logic [SW-1:0] r;
        r = '0;
        for (int i = 0; i < c; i++) r = r + SW'(m[i]);
        return r;
    endfunction

    always_comb begin
        for (int c = 0; c < NumChannels; c++) begin
            w_s[c]          = SW'(r_beat) * SW'(r_nact) + f_rank(r_mask, c);
            w_chan_valid[c] = (r_state == SEND) && r_mask[c] && (w_s[c] < NCH_S) && !r_done[c];
            w_chan_data[c]  = '0;
            if (w_chan_valid[c]) begin
                for (int k = 0; k < NumChannels; k++) begin
                    if (w_s[c] == SW'(k)) w_chan_data[c] = r_data[k*ChanWidth +: ChanWidth];
                end
            end
        end
    end

    // Channels already handshaked this beat show valid low, so they count as complete.
    assign w_beat_done = (r_state == SEND) && (&(~w_chan_valid | chan_ready_i));
    assign w_final     = w_beat_done && (r_beat == r_nbeat);
    assign w_ready     = (cfg_chan_en_i != '0) && ((r_state == IDLE) || w_final);
    assign w_accept    = valid_i && w_ready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_accept) w_state_nxt = SEND;
            SEND: if (w_final && !w_accept) w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_data  <= '0;
            r_mask  <= '0;
            r_nact  <= '0;
            r_nbeat <= '0;
            r_beat  <= '0;
            r_done  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_data  <= data_i;
                r_mask  <= cfg_chan_en_i;
                r_nact  <= f_popcount(cfg_chan_en_i);
                r_nbeat <= f_nbeat(f_popcount(cfg_chan_en_i));
                r_beat  <= '0;
                r_done  <= '0;
            end else if (r_state == SEND) begin
                if (w_beat_done) begin
                    r_beat <= r_beat + BW'(1);
                    r_done <= '0;
                end else begin
                    r_done <= r_done | (w_chan_valid & chan_ready_i);
                end
            end
        end
    end

    assign ready_o      = w_ready;
    assign chan_valid_o = w_chan_valid;
    assign chan_data_o  = w_chan_data;
    assign busy_o       = (r_state == SEND);
    assign cfg_err_o    = (cfg_chan_en_i == '0);

endmodule

// File: tb/tb_serial_link_chan_striper.sv
// Cycle-by-cycle vector bench for serial_link_chan_striper (4 channels x 32 bits).
module tb_serial_link_chan_striper;

    localparam int NC = 4;
    localparam int CW = 32;

    logic                      clk_i = 1'b0;
    logic                      rst_i;
    logic [NC-1:0]             cfg_chan_en_i;
    logic [NC*CW-1:0]          data_i;
    logic                      valid_i;
    logic                      ready_o;
    logic [NC-1:0][CW-1:0]     chan_data_o;
    logic [NC-1:0]             chan_valid_o;
    logic [NC-1:0]             chan_ready_i;
    logic                      busy_o;
    logic                      cfg_err_o;

    serial_link_chan_striper #(.NumChannels(NC), .ChanWidth(CW)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .cfg_chan_en_i(cfg_chan_en_i),
        .data_i       (data_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .chan_data_o  (chan_data_o),
        .chan_valid_o (chan_valid_o),
        .chan_ready_i (chan_ready_i),
        .busy_o       (busy_o),
        .cfg_err_o    (cfg_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        rst;
        logic [3:0]  mask;
        logic        vin;
        logic [7:0]  pid;
        logic [3:0]  crdy;
        logic        rdy;
        logic        busy;
        logic        err;
        logic [3:0]  cv;
        logic [15:0] sl;    // one nibble per channel: 0 idle, 1..4 = slice A..D
        logic [7:0]  epid;
    } vec_t;

    vec_t vq[$];
    int   checks = 0;
    int   errors = 0;
    int   step   = 0;

    function automatic logic [31:0] slice_val(input logic [7:0] pid, input int k);
        logic [15:0] hi;
        hi = 16'hAAAA + 16'(k) * 16'h1111;
        return {hi, 8'h00, pid};
    endfunction

    function automatic logic [127:0] payload(input logic [7:0] pid);
        return {slice_val(pid, 3), slice_val(pid, 2), slice_val(pid, 1), slice_val(pid, 0)};
    endfunction

    function automatic logic [127:0] exp_data(input logic [15:0] sl, input logic [7:0] pid);
        logic [127:0] d;
        logic [3:0]   code;
        d = '0;
        for (int c = 0; c < NC; c++) begin
            code = sl[c*4 +: 4];
            if (code != 4'd0) d[c*32 +: 32] = slice_val(pid, int'(code) - 1);
        end
        return d;
    endfunction

    task automatic add(input logic rst, input logic [3:0] mask, input logic vin,
                       input logic [7:0] pid, input logic [3:0] crdy, input logic rdy,
                       input logic busy, input logic err, input logic [3:0] cv,
                       input logic [15:0] sl, input logic [7:0] epid);
        vec_t v;
        v.rst = rst; v.mask = mask; v.vin = vin; v.pid = pid; v.crdy = crdy;
        v.rdy = rdy; v.busy = busy; v.err = err; v.cv = cv; v.sl = sl; v.epid = epid;
        vq.push_back(v);
    endtask

    task automatic drive(input logic rst, input logic [3:0] mask, input logic vin,
                         input logic [7:0] pid, input logic [3:0] crdy);
        rst_i         = rst;
        cfg_chan_en_i = mask;
        valid_i       = vin;
        data_i        = payload(pid);
        chan_ready_i  = crdy;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d actual %h required %h", nm, step, act, exp);
        end
    endtask

    task automatic chk_outs(input logic rdy, input logic busy, input logic err,
                            input logic [3:0] cv, input logic [127:0] dat);
        chk("ready_o",      128'(ready_o),      128'(rdy));
        chk("busy_o",       128'(busy_o),       128'(busy));
        chk("cfg_err_o",    128'(cfg_err_o),    128'(err));
        chk("chan_valid_o", 128'(chan_valid_o), 128'(cv));
        chk("chan_data_o",  128'(chan_data_o),  dat);
    endtask

    initial begin
        drive(1'b1, 4'hF, 1'b0, 8'd0, 4'hF);
        repeat (2) @(posedge clk_i);

        // full mask, lockstep and back-to-back
        add(0, 4'hF, 0, 0, 4'hF, 1, 0, 0, 4'h0, 16'h0000, 0);
        add(0, 4'hF, 1, 1, 4'hF, 1, 0, 0, 4'h0, 16'h0000, 0);
        for (int p = 2; p <= 8; p++)
            add(0, 4'hF, 1, 8'(p), 4'hF, 1, 1, 0, 4'hF, 16'h4321, 8'(p - 1));
        add(0, 4'hF, 0, 0, 4'hF, 1, 1, 0, 4'hF, 16'h4321, 8);
        add(0, 4'hF, 0, 0, 4'hF, 1, 0, 0, 4'h0, 16'h0000, 0);
        // mask 0101, back-to-back on the completing beat
        add(0, 4'h5, 1, 9,  4'hF, 1, 0, 0, 4'h0, 16'h0000, 0);
        add(0, 4'h5, 1, 10, 4'hF, 0, 1, 0, 4'h5, 16'h0201, 9);
        add(0, 4'h5, 1, 10, 4'hF, 1, 1, 0, 4'h5, 16'h0403, 9);
        add(0, 4'h5, 0, 0,  4'hF, 0, 1, 0, 4'h5, 16'h0201, 10);
        add(0, 4'h5, 0, 0,  4'hF, 1, 1, 0, 4'h5, 16'h0403, 10);
        // mask 0111
        add(0, 4'h7, 1, 11, 4'hF, 1, 0, 0, 4'h0, 16'h0000, 0);
        add(0, 4'h7, 0, 0,  4'hF, 0, 1, 0, 4'h7, 16'h0321, 11);
        add(0, 4'h7, 0, 0,  4'hF, 1, 1, 0, 4'h1, 16'h0004, 11);
        add(0, 4'h7, 0, 0,  4'hF, 1, 0, 0, 4'h0, 16'h0000, 0);
        // backpressure on ch2 for 5 cycles
        add(0, 4'hF, 1, 12, 4'hF, 1, 0, 0, 4'h0, 16'h0000, 0);
        add(0, 4'hF, 1, 13, 4'hB, 0, 1, 0, 4'hF, 16'h4321, 12);
        for (int i = 0; i < 4; i++)
            add(0, 4'hF, 1, 13, 4'hB, 0, 1, 0, 4'h4, 16'h0300, 12);
        add(0, 4'hF, 1, 13, 4'hF, 1, 1, 0, 4'h4, 16'h0300, 12);
        add(0, 4'hF, 0, 0,  4'hF, 1, 1, 0, 4'hF, 16'h4321, 13);
        add(0, 4'hF, 0, 0,  4'hF, 1, 0, 0, 4'h0, 16'h0000, 0);
        // mask change during a 0101 payload, then single channel
        add(0, 4'h5, 1, 14, 4'hF, 1, 0, 0, 4'h0, 16'h0000, 0);
        add(0, 4'h1, 0, 0,  4'hF, 0, 1, 0, 4'h5, 16'h0201, 14);
        add(0, 4'h1, 1, 15, 4'hF, 1, 1, 0, 4'h5, 16'h0403, 14);
        add(0, 4'h1, 0, 0,  4'hF, 0, 1, 0, 4'h1, 16'h0001, 15);
        add(0, 4'h1, 0, 0,  4'hF, 0, 1, 0, 4'h1, 16'h0002, 15);
        add(0, 4'h1, 0, 0,  4'hF, 0, 1, 0, 4'h1, 16'h0003, 15);
        add(0, 4'h1, 0, 0,  4'hF, 1, 1, 0, 4'h1, 16'h0004, 15);
        // zero mask: no accept; in-flight payload still drains
        add(0, 4'h0, 1, 16, 4'hF, 0, 0, 1, 4'h0, 16'h0000, 0);
        add(0, 4'h0, 1, 16, 4'hF, 0, 0, 1, 4'h0, 16'h0000, 0);
        add(0, 4'h1, 1, 16, 4'hF, 1, 0, 0, 4'h0, 16'h0000, 0);
        add(0, 4'h0, 0, 0,  4'hF, 0, 1, 1, 4'h1, 16'h0001, 16);
        add(0, 4'h0, 0, 0,  4'hF, 0, 1, 1, 4'h1, 16'h0002, 16);
        add(0, 4'h0, 0, 0,  4'hF, 0, 1, 1, 4'h1, 16'h0003, 16);
        add(0, 4'h0, 0, 0,  4'hF, 0, 1, 1, 4'h1, 16'h0004, 16);
        add(0, 4'h0, 0, 0,  4'hF, 0, 0, 1, 4'h0, 16'h0000, 0);
        // reset during beat 1 of a 0001 payload
        add(0, 4'h1, 1, 17, 4'hF, 1, 0, 0, 4'h0, 16'h0000, 0);
        add(0, 4'h1, 0, 0,  4'hF, 0, 1, 0, 4'h1, 16'h0001, 17);
        add(1, 4'h1, 0, 0,  4'hF, 0, 1, 0, 4'h1, 16'h0002, 17);
        add(0, 4'h1, 0, 0,  4'hF, 1, 0, 0, 4'h0, 16'h0000, 0);
        add(0, 4'h1, 1, 18, 4'hF, 1, 0, 0, 4'h0, 16'h0000, 0);
        add(0, 4'h1, 0, 0,  4'hF, 0, 1, 0, 4'h1, 16'h0001, 18);
        add(0, 4'h1, 0, 0,  4'hF, 0, 1, 0, 4'h1, 16'h0002, 18);
        add(0, 4'h1, 0, 0,  4'hF, 0, 1, 0, 4'h1, 16'h0003, 18);
        add(0, 4'h1, 0, 0,  4'hF, 1, 1, 0, 4'h1, 16'h0004, 18);
        add(0, 4'h1, 0, 0,  4'hF, 1, 0, 0, 4'h0, 16'h0000, 0);

        foreach (vq[i]) begin
            step = i;
            #1;
            drive(vq[i].rst, vq[i].mask, vq[i].vin, vq[i].pid, vq[i].crdy);
            @(negedge clk_i);
            chk_outs(vq[i].rdy, vq[i].busy, vq[i].err, vq[i].cv, exp_data(vq[i].sl, vq[i].epid));
            @(posedge clk_i);
        end

        // staggered per-channel handshakes: flits stay stable until their own handshake
        step = 1000;
        #1 drive(1'b0, 4'hF, 1'b1, 8'd20, 4'hF);
        @(negedge clk_i);
        chk_outs(1'b1, 1'b0, 1'b0, 4'h0, 128'd0);
        @(posedge clk_i);
        step = 1001;
        #1 drive(1'b0, 4'hF, 1'b0, 8'd0, 4'h1);
        @(negedge clk_i);
        chk_outs(1'b0, 1'b1, 1'b0, 4'hF, exp_data(16'h4321, 8'd20));
        @(posedge clk_i);
        step = 1002;
        #1 drive(1'b0, 4'hF, 1'b0, 8'd0, 4'h2);
        @(negedge clk_i);
        chk_outs(1'b0, 1'b1, 1'b0, 4'hE, exp_data(16'h4320, 8'd20));
        @(posedge clk_i);
        step = 1003;
        #1 drive(1'b0, 4'hF, 1'b0, 8'd0, 4'hC);
        @(negedge clk_i);
        chk_outs(1'b1, 1'b1, 1'b0, 4'hC, exp_data(16'h4300, 8'd20));
        @(posedge clk_i);
        step = 1004;
        #1 drive(1'b0, 4'hF, 1'b0, 8'd0, 4'hF);
        @(negedge clk_i);
        chk_outs(1'b1, 1'b0, 1'b0, 4'h0, 128'd0);
        @(posedge clk_i);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
